// File: rtl/shift_reg8_seq_if.sv
// Control/data bundle for the burst-capable universal shift register.
// The master drives the op/burst request; the slave returns register state.
interface shift_reg8_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
);
    logic [1:0]       op;
    logic [WIDTH-1:0] d_in;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output op, d_in, sin_l, sin_r, start, dir, amt,
        input  q, busy, done
    );

    modport slave (
        input  op, d_in, sin_l, sin_r, start, dir, amt,
        output q, busy, done
    );
endinterface

// File: rtl/shift_reg8_seq.sv
// Universal shift register (hold/shr/shl/load per-bit 4:1 mux) with a burst
// controller that shifts N positions, one per cycle, reporting busy/done.
module shift_reg8_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    shift_reg8_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    sel_t             sel_c;
    logic [WIDTH-1:0] shr_c;
    logic [WIDTH-1:0] shl_c;

    // Per-bit 4:1 selector shared by direct ops and burst steps
    function automatic logic mux4(
        input logic hold_b,
        input logic shr_b,
        input logic shl_b,
        input logic load_b,
        input sel_t sel
    );
        logic r;
        case (sel)
            SEL_HOLD: r = hold_b;
            SEL_SHR:  r = shr_b;
            SEL_SHL:  r = shl_b;
            SEL_LOAD: r = load_b;
            default:  r = hold_b;
        endcase
        return r;
    endfunction

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next state, mux select and next busy/done; start takes priority over op
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sel_c   = SEL_HOLD;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.amt != '0) begin
                        state_d = SHIFT;
                        cnt_d   = bus.amt;
                        dir_d   = bus.dir;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    sel_c = sel_t'(bus.op);
                end
            end
            SHIFT: begin
                sel_c = dir_q ? SEL_SHL : SEL_SHR;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dir_d   = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: fill bits are sampled on every shifting edge
    always_comb begin
        shr_c = {bus.sin_l, q_q[WIDTH-1:1]};
        shl_c = {q_q[WIDTH-2:0], bus.sin_r};
        q_d   = q_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            q_d[i] = mux4(q_q[i], shr_c[i], shl_c[i], bus.d_in[i], sel_c);
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    busy_done_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(busy_q && done_q));

endmodule
